// File: rtl/uart_rx.sv
// UART receive stage: 2-flop synchroniser, 8N1 deserialiser and a small
// first-word-fall-through byte FIFO with sticky frame/overrun flags.
`timescale 1ns/1ps

module uart_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] baud,
    input  logic        rx,
    input  logic        rd_en,
    input  logic        clr_err,
    output logic [7:0]  rx_data,
    output logic        rx_not_empty,
    output logic        rx_full,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t        state;
    logic          rx_m, rx_s;
    logic [31:0]   cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic bit_end, push, stop_bad, pop, full, push_ok, drop;

    assign bit_end  = (cnt == baud);
    assign push     = en && state == STOP && bit_end && rx_s;
    assign stop_bad = en && state == STOP && bit_end && !rx_s;
    assign full     = (count == FULL_CNT);
    assign pop      = rd_en && count != '0;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;

    assign rx_not_empty = (count != '0);
    assign rx_full      = full;
    assign rx_data      = rx_not_empty ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            busy    <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    cnt <= cnt + 32'd1;
                    if (cnt == (baud >> 1)) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    cnt <= cnt + 32'd1;
                    if (bit_end) begin
                        shift[bit_idx] <= rx_s;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end
                STOP: begin
                    cnt <= cnt + 32'd1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= BRK;
                        end
                    end
                end
                BRK: begin
                    // Held-low line must return high before a new start.
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (stop_bad)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;
            if (drop)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx: drives 8N1 frames on rx, queues expected
// bytes as they are sent and compares them against the FIFO head on read.
`timescale 1ns/1ps

module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst, en, rx, rd_en, clr_err;
    logic [31:0] baud;
    logic [7:0]  rx_data;
    logic        rx_not_empty, rx_full, busy, frame_err, overrun;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp;

    always #5 clk = ~clk;

    uart_rx #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .baud(baud), .rx(rx),
        .rd_en(rd_en), .clr_err(clr_err), .rx_data(rx_data),
        .rx_not_empty(rx_not_empty), .rx_full(rx_full), .busy(busy),
        .frame_err(frame_err), .overrun(overrun)
    );

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; leaves rx at the stop-bit level.
    task automatic send(input logic [7:0] d, input logic stop_bit,
                        input bit keep);
        if (keep) exp_q.push_back(d);
        rx = 1'b0;
        cycles(int'(baud) + 1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            cycles(int'(baud) + 1);
        end
        rx = stop_bit;
        cycles(int'(baud) + 1);
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        baud = 32'd3;
        cycles(3);
        tests++;
        if ({rx_data, rx_not_empty, rx_full, busy, frame_err, overrun} !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rx_data, rx_not_empty, rx_full, busy, frame_err, overrun});
        end
        rst = 1'b0; en = 1'b1;
        cycles(2);
    endtask

    task automatic test_single_byte;
        baud = 32'd3;
        send(8'hA5, 1'b1, 1'b1);
        cycles(4);
        tests++;
        if (rx_not_empty !== 1'b1) begin
            fails++; $display("FAIL single_not_empty: got %b want 1", rx_not_empty);
        end
        tests++;
        if (frame_err !== 1'b0) begin
            fails++; $display("FAIL single_frame_err: got %b want 0", frame_err);
        end
        exp = exp_q.pop_front();
        tests++;
        if (rx_data !== exp) begin
            fails++; $display("FAIL single_data: got %h want %h", rx_data, exp);
        end
        rd_en = 1'b1; cycles(1); rd_en = 1'b0;
        tests++;
        if (rx_not_empty !== 1'b0 || rx_data !== 8'h00) begin
            fails++;
            $display("FAIL single_after_pop: got ne=%b data=%h want ne=0 data=00",
                     rx_not_empty, rx_data);
        end
    endtask

    task automatic test_glitch;
        bit saw;
        baud = 32'd7;
        cycles(2);
        rx = 1'b0; cycles(2); rx = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (busy) saw = 1'b1;
        end
        tests++;
        if (saw !== 1'b1) begin
            fails++; $display("FAIL glitch_busy_pulse: got %b want 1", saw);
        end
        tests++;
        if ({busy, rx_not_empty, frame_err, overrun} !== 4'b0) begin
            fails++;
            $display("FAIL glitch_quiet: got %b want 0000",
                     {busy, rx_not_empty, frame_err, overrun});
        end
    endtask

    task automatic test_frame_err;
        baud = 32'd3;
        send(8'h3C, 1'b0, 1'b0);
        cycles(40);
        tests++;
        if ({frame_err, busy, rx_not_empty} !== 3'b110) begin
            fails++;
            $display("FAIL frame_held_low: got fe/busy/ne=%b want 110",
                     {frame_err, busy, rx_not_empty});
        end
        rx = 1'b1;
        cycles(5);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL frame_release_idle: got %b want 0", busy);
        end
        send(8'h5A, 1'b1, 1'b1);
        cycles(4);
        exp = exp_q.pop_front();
        tests++;
        if (rx_data !== exp || rx_not_empty !== 1'b1) begin
            fails++; $display("FAIL frame_next_byte: got %h want %h", rx_data, exp);
        end
        rd_en = 1'b1; cycles(1); rd_en = 1'b0;
        clr_err = 1'b1; cycles(1); clr_err = 1'b0;
        tests++;
        if (frame_err !== 1'b0) begin
            fails++; $display("FAIL frame_clr: got %b want 0", frame_err);
        end
    endtask

    task automatic test_overrun_wrap;
        baud = 32'd3;
        for (int b = 1; b <= 5; b++)
            send(8'(b), 1'b1, b <= 4);
        cycles(4);
        tests++;
        if ({rx_full, overrun} !== 2'b11) begin
            fails++;
            $display("FAIL overrun_flags: got full/ovr=%b want 11", {rx_full, overrun});
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            tests++;
            if (rx_data !== exp) begin
                fails++; $display("FAIL overrun_read%0d: got %h want %h", i, rx_data, exp);
            end
            rd_en = 1'b1; cycles(1); rd_en = 1'b0;
        end
        tests++;
        if (rx_not_empty !== 1'b0) begin
            fails++; $display("FAIL overrun_drained: got %b want 0", rx_not_empty);
        end
        send(8'h06, 1'b1, 1'b1);
        send(8'h07, 1'b1, 1'b1);
        cycles(4);
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            tests++;
            if (rx_data !== exp) begin
                fails++; $display("FAIL wrap_read%0d: got %h want %h", i, rx_data, exp);
            end
            rd_en = 1'b1; cycles(1); rd_en = 1'b0;
        end
        clr_err = 1'b1; cycles(1); clr_err = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++; $display("FAIL overrun_clr: got %b want 0", overrun);
        end
    endtask

    task automatic test_full_pop;
        int k;
        baud = 32'd3;
        send(8'h10, 1'b1, 1'b1);
        send(8'h20, 1'b1, 1'b1);
        send(8'h30, 1'b1, 1'b1);
        send(8'h40, 1'b1, 1'b1);
        cycles(4);
        tests++;
        if (rx_full !== 1'b1) begin
            fails++; $display("FAIL fullpop_filled: got %b want 1", rx_full);
        end
        // rd_en spans exactly the stop-sample edge (2 sync + detect + half + 9 bits).
        k = 3 + int'(baud >> 1) + 9 * (int'(baud) + 1);
        fork
            send(8'h55, 1'b1, 1'b0);
            begin
                cycles(k);
                exp = exp_q.pop_front();
                tests++;
                if (rx_data !== exp) begin
                    fails++; $display("FAIL fullpop_head: got %h want %h", rx_data, exp);
                end
                rd_en = 1'b1; cycles(1); rd_en = 1'b0;
            end
        join
        exp_q.push_back(8'h55);
        cycles(4);
        tests++;
        if ({rx_full, overrun} !== 2'b10) begin
            fails++;
            $display("FAIL fullpop_flags: got full/ovr=%b want 10", {rx_full, overrun});
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            tests++;
            if (rx_data !== exp) begin
                fails++; $display("FAIL fullpop_read%0d: got %h want %h", i, rx_data, exp);
            end
            rd_en = 1'b1; cycles(1); rd_en = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        baud = 32'd3;
        send(8'h11, 1'b1, 1'b1);
        cycles(4);
        d = 8'hC3;
        rx = 1'b0;
        cycles(int'(baud) + 1);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            cycles(int'(baud) + 1);
        end
        rx = d[3];
        cycles(2);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({rx_data, rx_not_empty, rx_full, busy, frame_err, overrun} !== 13'h0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {rx_data, rx_not_empty, rx_full, busy, frame_err, overrun});
        end
        exp_q.delete();
        rx = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(3);
        send(8'h81, 1'b1, 1'b1);
        cycles(4);
        exp = exp_q.pop_front();
        tests++;
        if (rx_data !== exp || rx_not_empty !== 1'b1) begin
            fails++; $display("FAIL reset_mid_next: got %h want %h", rx_data, exp);
        end
        rd_en = 1'b1; cycles(1); rd_en = 1'b0;
    endtask

    task automatic test_enable_drop;
        baud = 32'd3;
        fork
            send(8'h00, 1'b1, 1'b0);
            begin
                cycles(20);
                tests++;
                if (busy !== 1'b1) begin
                    fails++; $display("FAIL en_drop_busy_before: got %b want 1", busy);
                end
                en = 1'b0;
                cycles(2);
                tests++;
                if (busy !== 1'b0) begin
                    fails++; $display("FAIL en_drop_idle: got %b want 0", busy);
                end
            end
        join
        en = 1'b1;
        cycles(6);
        tests++;
        if ({busy, rx_not_empty, frame_err, overrun} !== 4'b0) begin
            fails++;
            $display("FAIL en_drop_quiet: got %b want 0000",
                     {busy, rx_not_empty, frame_err, overrun});
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_err();
        test_overrun_wrap();
        test_full_pop();
        test_reset_mid();
        test_enable_drop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage of the UART peripheral: oversamples the `rx` pin, deserialises 8N1 frames (LSB first), and queues received bytes in a small first-word-fall-through FIFO. The UART register block reads the FIFO into RDR and reflects the status outputs into STAT. The bit period uses the same convention as the transmitter: one bit lasts `baud + 1` clock cycles.

## Interface

**Parameters**
- `FIFO_DEPTH`, default 4. Number of byte entries. Must be a power of 2 and at least 2.

**Ports**
- `clk`, input, 1 bit. Single clock for the whole block.
- `rst`, input, 1 bit. Reset; asynchronous, active-high.
- `en`, input, 1 bit. Receiver enable. When low, the FSM is held in IDLE; FIFO contents are kept.
- `baud`, input, 32 bits. Bit period minus 1, in clocks. Supported range is 3 or greater.
- `rx`, input, 1 bit. Asynchronous serial line; idles high.
- `rd_en`, input, 1 bit. Pop the FIFO head. Ignored when the FIFO is empty.
- `clr_err`, input, 1 bit. One-cycle pulse that clears `frame_err` and `overrun`.
- `rx_data`, output, 8 bits. FIFO head. Reads 0 when the FIFO is empty.
- `rx_not_empty`, output, 1 bit. FIFO holds at least one byte.
- `rx_full`, output, 1 bit. FIFO holds `FIFO_DEPTH` bytes.
- `busy`, output, 1 bit. FSM is not in IDLE.
- `frame_err`, output, 1 bit. Sticky flag: a stop bit was sampled as 0.
- `overrun`, output, 1 bit. Sticky flag: a byte was dropped because the FIFO was full.

## Operation

**Input synchroniser**
- `rx` passes through 2 flops to give `rx_s`. Both flops reset to 1.

**FSM states**
- **IDLE**
  - Clear the counter (`cnt`, 32 bits).
  - If `en` and `rx_s == 0`, go to START.
- **START**
  - Increment `cnt`.
  - When `cnt == baud >> 1`, sample `rx_s`:
    - If 0, go to DATA with `cnt = 0` and `bit_idx = 0`.
    - If 1 (glitch), go to IDLE. No flags change.
- **DATA**
  - When `cnt == baud`, sample `rx_s` into `shift[bit_idx]`, clear `cnt`, and increment `bit_idx`.
  - After `bit_idx` 7 is sampled, go to STOP.
- **STOP**
  - When `cnt == baud`, sample `rx_s`:
    - If 1: push `shift` into the FIFO and go to IDLE.
    - If 0: set `frame_err`, discard the byte, and go to BREAK.
- **BREAK**
  - Wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line from re-triggering START.

**Enable and errors**
- Deasserting `en` in any state forces IDLE on the next edge. The partial byte is discarded and no flags change.
- Push while full: the byte is dropped and `overrun` is set. The FIFO is unchanged unless `rd_en` is asserted in the same cycle (see below).
- Flag priority: a set in the same cycle as `clr_err` wins, so the flag ends at 1.

**FIFO**
- Circular buffer with read/write pointers of log2(`FIFO_DEPTH`) bits, plus a count of log2(`FIFO_DEPTH`)+1 bits. Pointers wrap modulo `FIFO_DEPTH`.
- Simultaneous push and pop:
  - Both are performed and the count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and `overrun` is not set.
  - When empty, the pop is ignored and the push is performed.
- `rx_data` is the combinational head: `mem[rd_ptr]` when the count is non-zero, else 0.

## Timing

- **Reset values:**
  - `rx_data` = 0
  - `rx_not_empty` = 0
  - `rx_full` = 0
  - `busy` = 0
  - `frame_err` = 0
  - `overrun` = 0
  - FSM = IDLE
  - Pointers, count and `cnt` = 0
- Reset asserted mid-frame aborts the frame immediately (asynchronously). FIFO contents are lost.
- **Sample points,** relative to edge E, the first edge where IDLE sees `rx_s == 0`:
  - Start check at E + (`baud >> 1`) + 1.
  - Data bit i at start check + (i+1)·(`baud`+1).
  - Stop bit at start check + 9·(`baud`+1).
- **Latency:** pin falling edge to IDLE detection is 2 cycles (synchroniser), then on to E + 1.
- **Push edge:** the FIFO push happens on the stop-sample edge. `rx_not_empty`, `rx_full` and `rx_data` reflect it immediately after that edge.
- **Pop:** `rd_en` at edge P advances the head. The new `rx_data` is valid after P, with no wait states.
- **`busy`:** high from the edge entering START until the edge returning to IDLE. It includes BREAK.
- **Back-to-back frames:** the next start bit may begin immediately after the stop-sample point. IDLE detects it one cycle later, which is within the tolerance of the half-bit start check.

## Test plan

1. **Single byte.** `baud` = 3, `en` = 1, send 0xA5 8N1 → `rx_not_empty` = 1, `rx_data` = 0xA5, `frame_err` = 0. Pulse `rd_en` → `rx_not_empty` = 0, `rx_data` = 0.
2. **Glitch rejection.** `baud` = 7, drive `rx` low for 2 clocks, then high → `busy` pulses, then returns to 0. No push, and no flag is set.
3. **Framing error.** `baud` = 3, send 0x3C with stop bit = 0 and hold low 40 clocks, then release → `frame_err` = 1, FIFO empty, FSM in BREAK until release. Next byte 0x5A is received correctly. `clr_err` → `frame_err` = 0.
4. **Overrun and wrap.** `FIFO_DEPTH` = 4, send 0x01–0x05 without reading → `rx_full` = 1, `overrun` = 1. Four reads return 0x01–0x04. Then send 0x06, 0x07 → reads return 0x06, 0x07 (pointer wrap).
5. **Full with simultaneous pop.** Fill to 4. Assert `rd_en` on exactly the stop-sample edge of byte 0x55 → count stays 4, `overrun` = 0, last entry = 0x55.
6. **Reset and enable mid-frame.**
   - Assert `rst` during data bit 3 → all outputs 0 at once. After release, 0x81 is received correctly.
   - Drop `en` mid-frame → no push and no flags.
